// File: rtl/flow_control_stack.sv
// flow_control_stack: registered flow-opcode resolver with a hardware return-address stack and a latched interrupt flag.
// Define FLOW_STACK_GUARD_EN to make a push onto a full stack fault instead of overwriting the oldest entry.
module flow_control_stack #(
  parameter int WORD_WIDTH  = 32,
  parameter int PC_WIDTH    = 32,
  parameter int STACK_DEPTH = 8,
  parameter int PC_INCR     = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               valid,
  input  logic                               flush,
  input  logic [7:0]                         instruction,
  input  logic [WORD_WIDTH-1:0]              top,
  input  logic [WORD_WIDTH-1:0]              second,
  input  logic [PC_WIDTH-1:0]                pc,
  input  logic                               carry,
  input  logic                               overflow,
  input  logic                               interrupt,
  output logic                               out_valid,
  output logic                               branch,
  output logic                               jump,
  output logic                               ret,
  output logic [PC_WIDTH-1:0]                ret_addr,
  output logic                               fault,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               int_pending
);
  localparam logic [7:0] I_BRA = 8'h40, I_BC = 8'h41, I_BNC = 8'h42, I_BO = 8'h43, I_BNO = 8'h44,
                         I_BEQ = 8'h45, I_BNE = 8'h46, I_BLES = 8'h47, I_BLEQ = 8'h48,
                         I_BLESU = 8'h49, I_BLEQU = 8'h4A, I_BZ = 8'h4B, I_BNZ = 8'h4C,
                         I_BI = 8'h4D, I_BNI = 8'h4E, I_JMPI = 8'h4F, I_CALLI = 8'h50, I_RET = 8'h51;
  localparam int SW = $clog2(STACK_DEPTH);
  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic [DW-1:0] depth_q, depth_d;
  logic int_pending_q, int_pending_d;
  logic out_valid_q, branch_q, jump_q, ret_q, fault_q;
  logic branch_d, jump_d, fault_d;
  logic [PC_WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic act, ip, take, is_push, is_pop, full, empty, push_ok, push_flt, pop_ok;

  assign act     = valid & ~flush;
  assign ip      = int_pending_q | interrupt;
  assign is_push = act & (instruction == I_CALLI);
  assign is_pop  = act & (instruction == I_RET);
  assign full    = depth_q == FULL;
  assign empty   = depth_q == '0;
  assign pop_ok  = is_pop & ~empty;
`ifdef FLOW_STACK_GUARD_EN
  assign push_ok  = is_push & ~full;
  assign push_flt = is_push & full;
`else
  assign push_ok  = is_push;
  assign push_flt = 1'b0;
`endif

  always_comb begin
    take = 1'b0;
    case (instruction)
      I_BRA:   take = 1'b1;
      I_BC:    take = carry;
      I_BNC:   take = ~carry;
      I_BO:    take = overflow;
      I_BNO:   take = ~overflow;
      I_BEQ:   take = second == top;
      I_BNE:   take = second != top;
      I_BLES:  take = $signed(second) < $signed(top);
      I_BLEQ:  take = $signed(second) <= $signed(top);
      I_BLESU: take = second < top;
      I_BLEQU: take = second <= top;
      I_BZ:    take = top == '0;
      I_BNZ:   take = top != '0;
      I_BI:    take = ip;
      I_BNI:   take = ~ip;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    branch_d      = act & take;
    jump_d        = act & (instruction == I_JMPI || instruction == I_CALLI);
    fault_d       = push_flt | (is_pop & empty);
    ret_addr_d    = pop_ok ? mem[sp_q - SW'(1)] : '0;
    sp_d          = flush ? '0 : push_ok ? sp_q + SW'(1) : pop_ok ? sp_q - SW'(1) : sp_q;
    // a circular push onto a full stack overwrites the oldest entry, so occupancy saturates
    depth_d       = flush ? '0 : (push_ok & ~full) ? depth_q + DW'(1) : pop_ok ? depth_q - DW'(1) : depth_q;
    int_pending_d = flush ? 1'b0 : interrupt ? 1'b1 : (act & instruction == I_BI & ip) ? 1'b0 : int_pending_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q          <= '0;
      depth_q       <= '0;
      int_pending_q <= 1'b0;
      out_valid_q   <= 1'b0;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
      ret_q         <= 1'b0;
      fault_q       <= 1'b0;
      ret_addr_q    <= '0;
    end else begin
      sp_q          <= sp_d;
      depth_q       <= depth_d;
      int_pending_q <= int_pending_d;
      out_valid_q   <= act;
      branch_q      <= branch_d;
      jump_q        <= jump_d;
      ret_q         <= is_pop;
      fault_q       <= fault_d;
      ret_addr_q    <= ret_addr_d;
    end
  end

  always_ff @(posedge clk)
    if (!reset && push_ok) mem[sp_q] <= pc + PC_WIDTH'(PC_INCR);

  assign out_valid   = out_valid_q;
  assign branch      = branch_q;
  assign jump        = jump_q;
  assign ret         = ret_q;
  assign ret_addr    = ret_addr_q;
  assign fault       = fault_q;
  assign depth       = depth_q;
  assign int_pending = int_pending_q;
endmodule
